// File: rtl/aes_round_pipe_if.sv
// Handshake bundle for one AES round engine: an input channel carrying
// {state, key, last, tag} and an output channel carrying {state, tag}.
interface aes_round_pipe_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_data;
    logic [127:0]     in_key;
    logic             in_last;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_data;
    logic [TAG_W-1:0] out_tag;

    // Producer/consumer side that feeds the engine and drains its results
    modport master (
        output in_valid, in_data, in_key, in_last, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    // The round engine itself
    modport slave (
        input  in_valid, in_data, in_key, in_last, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/aes_round_pipe.sv
// Elastic AES-128 round: SubBytes -> ShiftRows -> MixColumns -> AddRoundKey.
// The four transforms sit at fixed positions; PIPE_STAGES picks which of
// them end in a register. Unregistered positions are pure combinational
// pass-throughs, so one generic position body covers every depth.
module aes_round_pipe #(
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic            clk,
    input  logic            rst,
    aes_round_pipe_if.slave bus
);
    if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_depth
        $error("aes_round_pipe: PIPE_STAGES must be 1..4, got %0d", PIPE_STAGES);
    end

    // Bit p set = position p (0 SB, 1 SR, 2 MC, 3 ARK) ends in a register.
    localparam logic [3:0] REG_MASK = (PIPE_STAGES == 1) ? 4'b1000 :
                                      (PIPE_STAGES == 2) ? 4'b1001 :
                                      (PIPE_STAGES == 3) ? 4'b1101 : 4'b1111;

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    // Byte index 4*c + r holds s(r,c); row r takes its byte from column c+r.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    // Occupancy of every position; unregistered positions never block.
    logic [3:0] full_vec;

    for (genvar gi = 0; gi < 4; gi++) begin : g_pos
        logic             v_in, l_in, v_out, l_out;
        logic [127:0]     s_in, k_in, s_f, s_out, k_out;
        logic [TAG_W-1:0] t_in, t_out;

        if (gi == 0) begin : g_src
            assign v_in = bus.in_valid;
            assign s_in = bus.in_data;
            assign k_in = bus.in_key;
            assign l_in = bus.in_last;
            assign t_in = bus.in_tag;
        end else begin : g_link
            assign v_in = g_pos[gi-1].v_out;
            assign s_in = g_pos[gi-1].s_out;
            assign k_in = g_pos[gi-1].k_out;
            assign l_in = g_pos[gi-1].l_out;
            assign t_in = g_pos[gi-1].t_out;
        end

        if (gi == 0) begin : g_sb
            assign s_f = sub_bytes(s_in);
        end else if (gi == 1) begin : g_sr
            assign s_f = shift_rows(s_in);
        end else if (gi == 2) begin : g_mc
            assign s_f = l_in ? s_in : mix_columns(s_in);
        end else begin : g_ark
            assign s_f = s_in ^ k_in;
        end

        if (REG_MASK[gi]) begin : g_reg
            logic             rdy, v_q;
            logic [127:0]     s_q;
            logic [TAG_W-1:0] t_q;

            // A slot can take new data if any slot from here to the output
            // has a hole, or the output is being drained this cycle.
            assign rdy = bus.out_ready | ~(&full_vec[3:gi]);

            // Stage register: refill whenever the slot is free or moving on
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q <= 1'b0;
                    s_q <= '0;
                    t_q <= '0;
                end else if (rdy) begin
                    v_q <= v_in;
                    if (v_in) begin
                        s_q <= s_f;
                        t_q <= t_in;
                    end
                end
            end

            assign v_out        = v_q;
            assign s_out        = s_q;
            assign t_out        = t_q;
            assign full_vec[gi] = v_q;

            if (gi < 3) begin : g_side
                logic [127:0] k_q;
                logic         l_q;

                // Key and final-round flag ride along until AddRoundKey
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        k_q <= '0;
                        l_q <= 1'b0;
                    end else if (rdy && v_in) begin
                        k_q <= k_in;
                        l_q <= l_in;
                    end
                end

                assign k_out = k_q;
                assign l_out = l_q;
            end else begin : g_side_end
                assign k_out = k_in;
                assign l_out = l_in;
            end
        end else begin : g_thru
            assign v_out        = v_in;
            assign s_out        = s_f;
            assign k_out        = k_in;
            assign l_out        = l_in;
            assign t_out        = t_in;
            assign full_vec[gi] = 1'b1;
        end
    end

    // Key and flag are consumed by ARK itself; nothing leaves with them.
    logic unused_tail;
    assign unused_tail = ^{g_pos[3].k_out, g_pos[3].l_out};

    assign bus.in_ready  = bus.out_ready | ~(&full_vec);
    assign bus.out_valid = g_pos[3].v_out;
    assign bus.out_data  = g_pos[3].s_out;
    assign bus.out_tag   = g_pos[3].t_out;
endmodule

// File: tb/tb_aes_round_pipe.sv
// Bench for aes_round_pipe: one engine per depth 1..4, driven one at a time
// and checked against a byte-matrix AES round model built from GF(2^8) math.
module tb_aes_round_pipe;
    localparam int TAG_W = 4;
    localparam int NP    = 4;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_tests;
    int   n_fail;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic             iv   [NP];
    logic [127:0]     id   [NP];
    logic [127:0]     ik   [NP];
    logic             il   [NP];
    logic [TAG_W-1:0] it   [NP];
    logic             ordy [NP];
    wire              irdy_w [NP];
    wire              ov_w   [NP];
    wire [127:0]      od_w   [NP];
    wire [TAG_W-1:0]  ot_w   [NP];

    for (genvar gi = 0; gi < NP; gi++) begin : g_dut
        aes_round_pipe_if #(.TAG_W(TAG_W)) pipe_if ();
        assign pipe_if.in_valid  = iv[gi];
        assign pipe_if.in_data   = id[gi];
        assign pipe_if.in_key    = ik[gi];
        assign pipe_if.in_last   = il[gi];
        assign pipe_if.in_tag    = it[gi];
        assign pipe_if.out_ready = ordy[gi];
        assign irdy_w[gi]        = pipe_if.in_ready;
        assign ov_w[gi]          = pipe_if.out_valid;
        assign od_w[gi]          = pipe_if.out_data;
        assign ot_w[gi]          = pipe_if.out_tag;
        aes_round_pipe #(.PIPE_STAGES(gi + 1), .TAG_W(TAG_W)) dut (
            .clk (clk),
            .rst (rst),
            .bus (pipe_if)
        );
    end

    // ---------------- reference model ----------------
    logic [7:0] sbox_ref [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box = affine transform of the multiplicative inverse in GF(2^8)
    task automatic build_sbox();
        logic [7:0] inv, xb, bb;
        for (int x = 0; x < 256; x++) begin
            xb  = 8'(x);
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                bb = 8'(b);
                if (x != 0 && gmul(xb, bb) == 8'h01) inv = bb;
            end
            sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [7:0] mc_coef(input int d);
        return (d == 0) ? 8'h02 : (d == 1) ? 8'h03 : 8'h01;
    endfunction

    function automatic logic [127:0] ref_round(input logic [127:0] din, input logic [127:0] key,
                                               input logic last);
        logic [7:0]   st [4][4];
        logic [7:0]   sh [4][4];
        logic [7:0]   acc;
        logic [127:0] res;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                st[r][c] = sbox_ref[din[127-8*(4*c+r) -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sh[r][c] = st[r][(c+r)%4];
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                if (last) acc = sh[r][c];
                else begin
                    acc = 8'h00;
                    for (int k = 0; k < 4; k++) acc = acc ^ gmul(mc_coef((k - r + 4) % 4), sh[k][c]);
                end
                res[127-8*(4*c+r) -: 8] = acc ^ key[127-8*(4*c+r) -: 8];
            end
        return res;
    endfunction

    typedef struct {
        logic [127:0]     data;
        logic [TAG_W-1:0] tag;
        int               edge_n;
    } exp_t;
    exp_t sb [$];

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- drive helpers (no checking) ----------------
    task automatic idle_all();
        for (int p = 0; p < NP; p++) begin
            iv[p] = 1'b0; id[p] = '0; ik[p] = '0; il[p] = 1'b0; it[p] = '0; ordy[p] = 1'b1;
        end
    endtask

    // Samples handshakes just after inputs settle, then moves to the next negedge.
    task automatic tick(input int p, output bit acc, output bit v, output logic [127:0] d,
                        output logic [TAG_W-1:0] t, output int e);
        #1;
        acc = (iv[p] === 1'b1) && (irdy_w[p] === 1'b1);
        v   = (ov_w[p] === 1'b1);
        d   = od_w[p];
        t   = ot_w[p];
        e   = cyc;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle_all();
        for (int p = 0; p < NP; p++) ordy[p] = 1'b0;
        @(negedge clk); #1;
        for (int p = 0; p < NP; p++) begin
            n_tests++; if (ov_w[p] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid depth=%0d got %b want 0", p+1, ov_w[p]); end
            n_tests++; if (irdy_w[p] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready depth=%0d got %b want 1", p+1, irdy_w[p]); end
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        for (int p = 0; p < NP; p++) begin
            n_tests++; if (ov_w[p] !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid depth=%0d got %b want 0", p+1, ov_w[p]); end
            n_tests++; if (od_w[p] !== 128'h0) begin n_fail++; $display("FAIL post_reset_data depth=%0d got %h want 0", p+1, od_w[p]); end
            n_tests++; if (ot_w[p] !== '0) begin n_fail++; $display("FAIL post_reset_tag depth=%0d got %h want 0", p+1, ot_w[p]); end
            n_tests++; if (irdy_w[p] !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready depth=%0d got %b want 1", p+1, irdy_w[p]); end
        end
        @(negedge clk);
        idle_all();
    endtask

    task automatic test_known_vectors();
        logic [127:0]     vin  [2];
        logic [127:0]     vkey [2];
        logic [127:0]     vexp [2];
        logic             vl   [2];
        logic [TAG_W-1:0] vt   [2];
        bit acc, v; logic [127:0] d; logic [TAG_W-1:0] t; int e, ea, k;
        vin[0] = 128'h193de3bea0f4e22b9ac68d2ae9f84808; vkey[0] = 128'ha0fafe1788542cb123a339392a6c7605;
        vexp[0] = 128'ha49c7ff2689f352b6b5bea43026a5049; vl[0] = 1'b0; vt[0] = 4'd3;
        vin[1] = 128'heb40f21e592e38848ba113e71bc342d2; vkey[1] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        vexp[1] = 128'h3925841d02dc09fbdc118597196a0b32; vl[1] = 1'b1; vt[1] = 4'd5;
        for (int i = 0; i < 2; i++) begin
            iv[1] = 1'b1; id[1] = vin[i]; ik[1] = vkey[i]; il[1] = vl[i]; it[1] = vt[i];
            tick(1, acc, v, d, t, ea);
            iv[1] = 1'b0; ik[1] = rand128();
            n_tests++; if (!acc) begin n_fail++; $display("FAIL kv_accept vec=%0d got 0 want 1", i); end
            k = 0; v = 1'b0;
            while (!v && k < 10) begin tick(1, acc, v, d, t, e); k++; end
            n_tests++; if (!v) begin n_fail++; $display("FAIL kv_timeout vec=%0d no out_valid within 10 cycles", i); end
            else begin
                n_tests++; if (d !== vexp[i]) begin n_fail++; $display("FAIL kv_data vec=%0d got %h want %h", i, d, vexp[i]); end
                n_tests++; if (t !== vt[i]) begin n_fail++; $display("FAIL kv_tag vec=%0d got %h want %h", i, t, vt[i]); end
                n_tests++; if (e - ea != 2) begin n_fail++; $display("FAIL kv_latency vec=%0d got %0d want 2", i, e - ea); end
            end
        end
        idle_all();
    endtask

    task automatic test_back_to_back(input int p);
        int sent, rcv, prev_e, miss, e;
        bit acc, v; logic [127:0] d; logic [TAG_W-1:0] t; exp_t x;
        sent = 0; rcv = 0; prev_e = 0; miss = 0;
        sb.delete(); idle_all();
        for (int k = 0; k < 40 && rcv < 8; k++) begin
            if (sent < 8) begin
                iv[p] = 1'b1; id[p] = rand128(); ik[p] = rand128();
                il[p] = 1'($urandom_range(0, 1)); it[p] = TAG_W'(sent);
            end else iv[p] = 1'b0;
            tick(p, acc, v, d, t, e);
            if (iv[p] && !acc) miss++;
            if (acc) begin
                x.data = ref_round(id[p], ik[p], il[p]); x.tag = it[p]; x.edge_n = e;
                sb.push_back(x); sent++;
            end
            if (v) begin
                if (sb.size() == 0) begin n_tests++; n_fail++; $display("FAIL b2b_spurious depth=%0d got output %h want none", p+1, d); end
                else begin
                    x = sb.pop_front();
                    n_tests++; if (d !== x.data) begin n_fail++; $display("FAIL b2b_data depth=%0d idx=%0d got %h want %h", p+1, rcv, d, x.data); end
                    n_tests++; if (t !== TAG_W'(rcv)) begin n_fail++; $display("FAIL b2b_tag depth=%0d got %0d want %0d", p+1, t, rcv); end
                    n_tests++; if (e - x.edge_n != p + 1) begin n_fail++; $display("FAIL b2b_latency depth=%0d got %0d want %0d", p+1, e - x.edge_n, p+1); end
                    if (rcv > 0) begin
                        n_tests++; if (e != prev_e + 1) begin n_fail++; $display("FAIL b2b_gap depth=%0d idx=%0d got gap %0d want 1", p+1, rcv, e - prev_e); end
                    end
                    prev_e = e; rcv++;
                end
            end
        end
        n_tests++; if (rcv != 8) begin n_fail++; $display("FAIL b2b_count depth=%0d got %0d want 8", p+1, rcv); end
        n_tests++; if (miss != 0) begin n_fail++; $display("FAIL b2b_in_ready depth=%0d got %0d stalls want 0", p+1, miss); end
        idle_all();
    endtask

    task automatic test_backpressure(input int p);
        int rcv, e;
        bit acc, v; logic [127:0] d; logic [TAG_W-1:0] t; exp_t x;
        rcv = 0;
        sb.delete(); idle_all(); ordy[p] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            iv[p] = 1'b1; id[p] = rand128(); ik[p] = rand128();
            il[p] = 1'($urandom_range(0, 1)); it[p] = TAG_W'($urandom_range(0, 15));
            tick(p, acc, v, d, t, e);
            if (acc) begin x.data = ref_round(id[p], ik[p], il[p]); x.tag = it[p]; x.edge_n = e; sb.push_back(x); end
            if (v) begin
                n_tests++;
                if (sb.size() == 0 || d !== sb[0].data || t !== sb[0].tag) begin
                    n_fail++; $display("FAIL bp_hold depth=%0d got %h/%h want head of %0d queued", p+1, d, t, sb.size());
                end
            end
        end
        n_tests++; if (sb.size() != p + 1) begin n_fail++; $display("FAIL bp_accepted depth=%0d got %0d want %0d", p+1, sb.size(), p+1); end
        #1;
        n_tests++; if (irdy_w[p] !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready depth=%0d got %b want 0", p+1, irdy_w[p]); end
        n_tests++; if (ov_w[p] !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid depth=%0d got %b want 1", p+1, ov_w[p]); end
        iv[p] = 1'b0; ordy[p] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick(p, acc, v, d, t, e);
            if (v) begin
                if (sb.size() == 0) begin n_tests++; n_fail++; $display("FAIL bp_extra depth=%0d got output %h want none", p+1, d); end
                else begin
                    x = sb.pop_front();
                    n_tests++; if (d !== x.data || t !== x.tag) begin n_fail++; $display("FAIL bp_drain depth=%0d got %h/%h want %h/%h", p+1, d, t, x.data, x.tag); end
                    rcv++;
                end
            end
        end
        n_tests++; if (rcv != p + 1) begin n_fail++; $display("FAIL bp_drain_count depth=%0d got %0d want %0d", p+1, rcv, p+1); end
        idle_all();
    endtask

    task automatic test_random(input int p, input int n);
        int sent, rcv, e;
        bit acc, v; logic [127:0] d; logic [TAG_W-1:0] t; exp_t x;
        sent = 0; rcv = 0;
        sb.delete(); idle_all();
        for (int k = 0; k < 20 * n && rcv < n; k++) begin
            ordy[p] = 1'($urandom_range(0, 1));
            if (sent < n && !(iv[p] && !acc && k > 0)) begin
                iv[p] = 1'($urandom_range(0, 1)); id[p] = rand128(); ik[p] = rand128();
                il[p] = 1'($urandom_range(0, 1)); it[p] = TAG_W'($urandom_range(0, 15));
            end else if (sent >= n) iv[p] = 1'b0;
            tick(p, acc, v, d, t, e);
            if (acc) begin x.data = ref_round(id[p], ik[p], il[p]); x.tag = it[p]; x.edge_n = e; sb.push_back(x); sent++; end
            if (v && ordy[p]) begin
                if (sb.size() == 0) begin n_tests++; n_fail++; $display("FAIL rnd_spurious depth=%0d got output %h want none", p+1, d); end
                else begin
                    x = sb.pop_front();
                    n_tests++; if (d !== x.data || t !== x.tag) begin n_fail++; $display("FAIL rnd_data depth=%0d idx=%0d got %h/%h want %h/%h", p+1, rcv, d, t, x.data, x.tag); end
                    rcv++;
                end
            end
        end
        n_tests++; if (rcv != n) begin n_fail++; $display("FAIL rnd_count depth=%0d got %0d want %0d", p+1, rcv, n); end
        idle_all();
    endtask

    task automatic test_reset_midflight(input int p);
        int nacc, nout, e, ea, k;
        bit acc, v; logic [127:0] d; logic [TAG_W-1:0] t;
        nacc = 0; nout = 0;
        idle_all(); ordy[p] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv[p] = 1'b1; id[p] = rand128(); ik[p] = rand128(); il[p] = 1'b0; it[p] = TAG_W'(i + 1);
            tick(p, acc, v, d, t, e);
            if (acc) nacc++;
        end
        iv[p] = 1'b0;
        n_tests++; if (nacc != 3) begin n_fail++; $display("FAIL mid_fill depth=%0d got %0d want 3", p+1, nacc); end
        rst = 1'b1; #1;
        n_tests++; if (ov_w[p] !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid depth=%0d got %b want 0", p+1, ov_w[p]); end
        n_tests++; if (od_w[p] !== 128'h0) begin n_fail++; $display("FAIL mid_rst_data depth=%0d got %h want 0", p+1, od_w[p]); end
        n_tests++; if (ot_w[p] !== '0) begin n_fail++; $display("FAIL mid_rst_tag depth=%0d got %h want 0", p+1, ot_w[p]); end
        @(negedge clk);
        rst = 1'b0; ordy[p] = 1'b1;
        for (int i = 0; i < 10; i++) begin tick(p, acc, v, d, t, e); if (v) nout++; end
        n_tests++; if (nout != 0) begin n_fail++; $display("FAIL mid_ghost depth=%0d got %0d outputs want 0", p+1, nout); end
        iv[p] = 1'b1; id[p] = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        ik[p] = 128'ha0fafe1788542cb123a339392a6c7605; il[p] = 1'b0; it[p] = 4'd9;
        tick(p, acc, v, d, t, ea);
        iv[p] = 1'b0;
        n_tests++; if (!acc) begin n_fail++; $display("FAIL mid_accept depth=%0d got 0 want 1", p+1); end
        k = 0; v = 1'b0;
        while (!v && k < 10) begin tick(p, acc, v, d, t, e); k++; end
        n_tests++; if (!v) begin n_fail++; $display("FAIL mid_timeout depth=%0d no output within 10 cycles", p+1); end
        else begin
            n_tests++; if (d !== 128'ha49c7ff2689f352b6b5bea43026a5049 || t !== 4'd9) begin n_fail++; $display("FAIL mid_after data/tag got %h/%h want a49c7ff2689f352b6b5bea43026a5049/9", d, t); end
            n_tests++; if (e - ea != p + 1) begin n_fail++; $display("FAIL mid_latency got %0d want %0d", e - ea, p+1); end
        end
        idle_all();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        idle_all();
        build_sbox();
        test_reset();
        test_known_vectors();
        for (int p = 0; p < NP; p++) test_back_to_back(p);
        for (int p = 0; p < NP; p++) test_backpressure(p);
        test_random(1, 1000);
        test_random(0, 300);
        test_random(2, 300);
        test_random(3, 300);
        test_reset_midflight(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
